// File: rtl/vproc_pkg.sv
// Shared vector-processor types: element width encoding and widening-unpacker states.
package vproc_pkg;

    typedef enum logic [1:0] {
        VSEW_8       = 2'b00,
        VSEW_16      = 2'b01,
        VSEW_32      = 2'b10,
        VSEW_INVALID = 2'b11
    } cfg_vsew;

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        LO    = 2'b10,
        HI    = 2'b11
    } widen_unpack_state;

endpackage

// File: rtl/vproc_widen_ext.sv
// Extends a half source word to a full operand word (elements to 2*SEW) and
// replicates the per-element byte-mask bit across the widened element.
module vproc_widen_ext
    import vproc_pkg::*;
#(
    parameter int unsigned OP_W = 64
) (
    input  logic [OP_W/2-1:0]  half_data,
    input  logic [OP_W/16-1:0] half_mask,
    input  cfg_vsew            vsew,
    input  logic               sign,
    output logic [OP_W-1:0]    ext_data,
    output logic [OP_W/8-1:0]  ext_mask
);

    logic [7:0]  elem8;
    logic [15:0] elem16;

    always_comb begin
        ext_data = '0;
        ext_mask = '0;
        elem8    = '0;
        elem16   = '0;
        if (vsew == VSEW_8) begin
            for (int unsigned k = 0; k < OP_W/16; k++) begin
                elem8              = half_data[8*k +: 8];
                ext_data[16*k +: 16] = {{8{sign & elem8[7]}}, elem8};
                ext_mask[2*k +: 2]   = {2{half_mask[k]}};
            end
        end else if (vsew == VSEW_16) begin
            // a 16-bit element's mask is carried by its lower byte lane
            for (int unsigned k = 0; k < OP_W/32; k++) begin
                elem16               = half_data[16*k +: 16];
                ext_data[32*k +: 32] = {{16{sign & elem16[15]}}, elem16};
                ext_mask[4*k +: 4]   = {4{half_mask[2*k]}};
            end
        end
    end

endmodule

// File: rtl/vproc_vreg_widen_unpack.sv
// Splits widening source words into two extended beats (low half first) and
// passes other words through; registered output with valid/ready on both sides.
// Optional stall counter port is enabled by VPROC_WIDEN_STALL_CNT_EN.
module vproc_vreg_widen_unpack
    import vproc_pkg::*;
#(
    parameter int unsigned OP_W           = 64,
    parameter logic        DONT_CARE_ZERO = 1'b0
) (
    input  logic              clk_i,
    input  logic              sync_rst_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  cfg_vsew           vsew_i,
    input  logic              widen_i,
    input  logic              sign_i,
    input  logic [OP_W-1:0]   in_data_i,
    input  logic [OP_W/8-1:0] in_mask_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [OP_W-1:0]   out_data_o,
    output logic [OP_W/8-1:0] out_mask_o,
    output logic              out_last_o,
`ifdef VPROC_WIDEN_STALL_CNT_EN
    output logic [31:0]       stall_cnt_o,
`endif
    output logic              busy_o
);

    widen_unpack_state state_q;

    logic [OP_W-1:0]   data_q;
    logic [OP_W/8-1:0] mask_q;
    logic              last_q;
    logic [OP_W-1:0]   hi_data_q;
    logic [OP_W/8-1:0] hi_mask_q;

    logic [OP_W-1:0]   lo_ext_data, hi_ext_data;
    logic [OP_W/8-1:0] lo_ext_mask, hi_ext_mask;

    logic accept;
    logic eff_widen;

    vproc_widen_ext #(.OP_W(OP_W)) u_ext_lo (
        .half_data (in_data_i[OP_W/2-1:0]),
        .half_mask (in_mask_i[OP_W/16-1:0]),
        .vsew      (vsew_i),
        .sign      (sign_i),
        .ext_data  (lo_ext_data),
        .ext_mask  (lo_ext_mask)
    );

    vproc_widen_ext #(.OP_W(OP_W)) u_ext_hi (
        .half_data (in_data_i[OP_W-1:OP_W/2]),
        .half_mask (in_mask_i[OP_W/8-1:OP_W/16]),
        .vsew      (vsew_i),
        .sign      (sign_i),
        .ext_data  (hi_ext_data),
        .ext_mask  (hi_ext_mask)
    );

    assign in_ready_o  = (state_q == EMPTY) |
                         (((state_q == ONE) | (state_q == HI)) & out_ready_i);
    assign accept      = in_valid_i & in_ready_o;
    assign eff_widen   = widen_i & ((vsew_i == VSEW_8) | (vsew_i == VSEW_16));
    assign out_valid_o = (state_q != EMPTY);
    assign busy_o      = (state_q != EMPTY);
    assign out_last_o  = last_q;
    assign out_data_o  = out_valid_o ? data_q : (DONT_CARE_ZERO ? '0 : 'x);
    assign out_mask_o  = out_valid_o ? mask_q : (DONT_CARE_ZERO ? '0 : 'x);

    always_ff @(posedge clk_i) begin
        if (sync_rst_i) begin
            state_q <= EMPTY;
            last_q  <= 1'b0;
        end else begin
            // a new word may load both from EMPTY and when the final beat drains
            if (accept) begin
                if (eff_widen) begin
                    state_q   <= LO;
                    data_q    <= lo_ext_data;
                    mask_q    <= lo_ext_mask;
                    last_q    <= 1'b0;
                    hi_data_q <= hi_ext_data;
                    hi_mask_q <= hi_ext_mask;
                end else begin
                    state_q <= ONE;
                    data_q  <= in_data_i;
                    mask_q  <= in_mask_i;
                    last_q  <= 1'b1;
                end
            end else if (out_ready_i) begin
                case (state_q)
                    LO: begin
                        state_q <= HI;
                        data_q  <= hi_data_q;
                        mask_q  <= hi_mask_q;
                        last_q  <= 1'b1;
                    end
                    ONE, HI: begin
                        state_q <= EMPTY;
                        last_q  <= 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef VPROC_WIDEN_STALL_CNT_EN
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk_i) begin
        if (sync_rst_i) begin
            stall_cnt_q <= '0;
        end else if (out_valid_o & ~out_ready_i & (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_vproc_vreg_widen_unpack.sv
// Directed bench for vproc_vreg_widen_unpack at OP_W=32 with hand-computed beats.
module tb_vproc_vreg_widen_unpack;
    import vproc_pkg::*;

    localparam int unsigned OP_W = 32;

    logic              clk_i = 1'b0;
    logic              sync_rst_i;
    logic              in_valid_i;
    logic              in_ready_o;
    cfg_vsew           vsew_i;
    logic              widen_i;
    logic              sign_i;
    logic [OP_W-1:0]   in_data_i;
    logic [OP_W/8-1:0] in_mask_i;
    logic              out_valid_o;
    logic              out_ready_i;
    logic [OP_W-1:0]   out_data_o;
    logic [OP_W/8-1:0] out_mask_o;
    logic              out_last_o;
    logic              busy_o;
`ifdef VPROC_WIDEN_STALL_CNT_EN
    logic [31:0]       stall_cnt_o;
    logic [31:0]       stall_base;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk_i = ~clk_i;

    vproc_vreg_widen_unpack #(
        .OP_W           (OP_W),
        .DONT_CARE_ZERO (1'b1)
    ) dut (
        .clk_i       (clk_i),
        .sync_rst_i  (sync_rst_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .vsew_i      (vsew_i),
        .widen_i     (widen_i),
        .sign_i      (sign_i),
        .in_data_i   (in_data_i),
        .in_mask_i   (in_mask_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_data_o  (out_data_o),
        .out_mask_o  (out_mask_o),
        .out_last_o  (out_last_o),
`ifdef VPROC_WIDEN_STALL_CNT_EN
        .stall_cnt_o (stall_cnt_o),
`endif
        .busy_o      (busy_o)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // advance one clock; inputs are driven and outputs sampled 1 time unit after the edge
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic v, input cfg_vsew sew, input logic w, input logic s,
                         input logic [OP_W-1:0] d, input logic [OP_W/8-1:0] m);
        in_valid_i = v;
        vsew_i     = sew;
        widen_i    = w;
        sign_i     = s;
        in_data_i  = d;
        in_mask_i  = m;
    endtask

    task automatic check_beat(input string tag, input logic [OP_W-1:0] d,
                              input logic [OP_W/8-1:0] m, input logic l);
        check({tag, ".valid"}, 64'(out_valid_o), 64'd1);
        check({tag, ".data"},  64'(out_data_o),  64'(d));
        check({tag, ".mask"},  64'(out_mask_o),  64'(m));
        check({tag, ".last"},  64'(out_last_o),  64'(l));
    endtask

    logic [OP_W-1:0] words [4];

    initial begin
        words[0] = 32'hA5A5_0001;
        words[1] = 32'h0000_FFFF;
        words[2] = 32'hDEAD_BEEF;
        words[3] = 32'h8000_0002;

        sync_rst_i  = 1'b1;
        out_ready_i = 1'b1;
        drive(1'b0, VSEW_8, 1'b0, 1'b0, '0, '0);
        step();
        step();
        check("rst.valid", 64'(out_valid_o), 64'd0);
        check("rst.busy",  64'(busy_o),      64'd0);
        check("rst.last",  64'(out_last_o),  64'd0);
        check("rst.data",  64'(out_data_o),  64'd0);
        check("rst.ready", 64'(in_ready_o),  64'd1);
        sync_rst_i = 1'b0;
        step();

        // SEW8 widen, signed, followed directly by the same word unsigned
        drive(1'b1, VSEW_8, 1'b1, 1'b1, 32'h807F_01FF, 4'b1010);
        step();
        drive(1'b0, VSEW_8, 1'b0, 1'b0, '0, '0);
        check_beat("s8s.b0", 32'h0001_FFFF, 4'b1100, 1'b0);
        check("s8s.b0.ready", 64'(in_ready_o), 64'd0);
        step();
        check_beat("s8s.b1", 32'hFF80_007F, 4'b1100, 1'b1);
        drive(1'b1, VSEW_8, 1'b1, 1'b0, 32'h807F_01FF, 4'b1010);
        check("s8s.b1.ready", 64'(in_ready_o), 64'd1);
        step();
        drive(1'b0, VSEW_8, 1'b0, 1'b0, '0, '0);
        check_beat("s8u.b0", 32'h0001_00FF, 4'b1100, 1'b0);
        step();
        check_beat("s8u.b1", 32'h0080_007F, 4'b1100, 1'b1);
        step();
        check("s8u.drain.busy", 64'(busy_o), 64'd0);

        // SEW16 widen, signed, with a one-cycle stall on the low beat
        drive(1'b1, VSEW_16, 1'b1, 1'b1, 32'h8000_7FFF, 4'b0100);
        step();
        drive(1'b0, VSEW_8, 1'b0, 1'b0, '0, '0);
        out_ready_i = 1'b0;
        check_beat("s16.b0", 32'h0000_7FFF, 4'b0000, 1'b0);
        step();
        check_beat("s16.b0.hold", 32'h0000_7FFF, 4'b0000, 1'b0);
        out_ready_i = 1'b1;
        step();
        check_beat("s16.b1", 32'hFFFF_8000, 4'b1111, 1'b1);
        step();
        check("s16.drain.valid", 64'(out_valid_o), 64'd0);

        // four pass-through words back to back, then a 3-cycle output stall
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, VSEW_16, 1'b0, 1'b1, words[i], 4'(i + 5));
            step();
            check_beat($sformatf("pass%0d", i), words[i], 4'(i + 5), 1'b1);
        end
        drive(1'b0, VSEW_8, 1'b0, 1'b0, '0, '0);
        out_ready_i = 1'b0;
        #1;
        check("stall.ready", 64'(in_ready_o), 64'd0);
`ifdef VPROC_WIDEN_STALL_CNT_EN
        stall_base = stall_cnt_o;
`endif
        for (int i = 0; i < 3; i++) begin
            step();
            check_beat($sformatf("stall%0d", i), words[3], 4'd8, 1'b1);
        end
`ifdef VPROC_WIDEN_STALL_CNT_EN
        check("stall.cnt", 64'(stall_cnt_o - stall_base), 64'd3);
`endif
        out_ready_i = 1'b1;
        step();
        check("stall.drain.busy", 64'(busy_o), 64'd0);

        // widening request at SEW32 degrades to pass-through
        drive(1'b1, VSEW_32, 1'b1, 1'b1, 32'h1234_5678, 4'b0110);
        step();
        drive(1'b0, VSEW_8, 1'b0, 1'b0, '0, '0);
        check_beat("s32w", 32'h1234_5678, 4'b0110, 1'b1);
        step();
        check("s32w.drain.valid", 64'(out_valid_o), 64'd0);

        // reset while in LO drops the pending high half
        drive(1'b1, VSEW_8, 1'b1, 1'b1, 32'h807F_01FF, 4'b1111);
        step();
        drive(1'b0, VSEW_8, 1'b0, 1'b0, '0, '0);
        check_beat("rstlo.b0", 32'h0001_FFFF, 4'b1111, 1'b0);
        sync_rst_i = 1'b1;
        step();
        sync_rst_i = 1'b0;
        check("rstlo.valid", 64'(out_valid_o), 64'd0);
        check("rstlo.busy",  64'(busy_o),      64'd0);
        check("rstlo.data",  64'(out_data_o),  64'd0);
        step();
        check("rstlo.nohi.valid", 64'(out_valid_o), 64'd0);
        drive(1'b1, VSEW_16, 1'b0, 1'b0, 32'hCAFE_F00D, 4'b0011);
        step();
        drive(1'b0, VSEW_8, 1'b0, 1'b0, '0, '0);
        check_beat("rstlo.next", 32'hCAFE_F00D, 4'b0011, 1'b1);
        step();
        check("end.busy", 64'(busy_o), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vproc_vreg_widen_unpack.md
Name: vproc_vreg_widen_unpack

Overview:
- Streams vector-register words into execution-unit operands; the inverse of the result packer's narrowing path.
- For widening ops, each OP_W source word is split into two output beats, low half first, then high half. Each element is sign- or zero-extended to 2*SEW, and its byte-mask bits are replicated to match.
- Non-widening words pass through in one beat.
- Sits between the vector register read port and the lane operand registers. It is fully registered and uses valid/ready on both sides.

Parameters:
- OP_W, 64, operand/data width in bits; multiple of 32.
- DONT_CARE_ZERO, 1'b0, drive '0 instead of 'x on out_data_o/out_mask_o while out_valid_o=0.

Ports:
- clk_i  in  1  clock.
- sync_rst_i  in  1  synchronous active-high reset.
- in_valid_i  in  1  source word valid.
- in_ready_o  out  1  block accepts source word.
- vsew_i  in  vproc_pkg::cfg_vsew  source element width; sampled on input handshake.
- widen_i  in  1  widening op; sampled on input handshake.
- sign_i  in  1  1=sign-extend, 0=zero-extend; sampled on input handshake.
- in_data_i  in  OP_W  source register word.
- in_mask_i  in  OP_W/8  source byte mask.
- out_valid_o  out  1  operand beat valid.
- out_ready_i  in  1  consumer accepts beat.
- out_data_o  out  OP_W  operand beat.
- out_mask_o  out  OP_W/8  operand byte mask.
- out_last_o  out  1  beat is final beat of its source word.
- busy_o  out  1  state != EMPTY.

Behaviour:
- States:
  - EMPTY: nothing held.
  - ONE: a single pass-through beat is held.
  - LO: low half is presented and the high half is pending.
  - HI: high half is presented.
- Reset values: state=EMPTY, out_valid_o=0, out_last_o=0, busy_o=0. out_data_o/out_mask_o are 0 if DONT_CARE_ZERO, else x.
- in_ready_o = (state==EMPTY) | ((state==ONE | state==HI) & out_ready_i). It is combinational from state and out_ready_i. It is never asserted in LO.
- Latency: accept in cycle t, beat visible in cycle t+1. Back-to-back single beats give 1 word/cycle; widening gives 1 word per 2 cycles.
- On accept, the mode is effectively widening only when widen_i=1 and vsew_i is VSEW_8 or VSEW_16:
  - Effective widening: go to LO. Register the extended low half and keep the extended high half in an internal buffer.
  - Otherwise (including widen_i=1 with VSEW_32): go to ONE, with out_data_o=in_data_i, out_mask_o=in_mask_i, out_last_o=1.
- Transitions:
  - LO + out_ready_i: go to HI with the buffered high half and out_last_o=1.
  - ONE/HI + out_ready_i: go to LO or ONE if a new word is accepted in the same cycle, else EMPTY.
  - No out_ready_i: hold. Output data, mask and last stay stable while out_valid_o=1 and not accepted.
- Widening arithmetic, with N=OP_W/SEW source elements; beat b in {0,1} covers elements b*N/2 .. b*N/2+N/2-1.
  - Output element k (2*SEW wide) = extend(src element b*N/2+k).
  - Mask, SEW8→16: out_mask[2k] = out_mask[2k+1] = in_mask[b*N/2+k].
  - Mask, SEW16→32: out_mask[4k..4k+3] all = in_mask[2*(b*N/2+k)].
- Mode inputs (vsew_i, widen_i, sign_i) are ignored when no handshake occurs.
- Reset while in LO, HI or ONE: the pending high half and held beat are discarded, and out_valid_o=0 in the next cycle.
- No error output. Illegal widening (VSEW_32) degrades to pass-through as stated above.

Optional Feature:
- Macro VPROC_WIDEN_STALL_CNT_EN.
- When defined: adds output port stall_cnt_o (32 bits). It counts cycles with out_valid_o=1 & out_ready_i=0, saturates at 2^32-1 and clears on sync_rst_i.
- When undefined: the port and counter are absent, and behaviour is otherwise identical.

Decomposition:
- In vproc_pkg: cfg_vsew (existing), plus a new enum widen_unpack_state {EMPTY, ONE, LO, HI}.
- Sub-module vproc_widen_ext: combinational. Inputs are a half word, vsew and sign; outputs are the extended full-width data and replicated mask. It is instantiated twice, for the low and high halves.

Test Plan:
- OP_W=32, VSEW_8, widen=1, sign=1, in_data=0x807F01FF, in_mask=0b1010, out_ready=1:
  - beat0: data 0x0001FFFF, mask 0b1100, last=0.
  - beat1: data 0xFF80007F, mask 0b1100, last=1.
  - in_ready_o=0 during beat0.
- Same word with sign=0 → beat1 is 0x0080007F.
- VSEW_16, widen=1, sign=1, in_data=0x8000_7FFF, in_mask=0b0100 → beat0: 0x00007FFF mask 0b0000; beat1: 0xFFFF8000 mask 0b1111.
- Stream of 4 non-widening words with out_ready=1 → 4 beats on consecutive cycles, each last=1. Then drop out_ready for 3 cycles → output held stable and stall_cnt_o +3 (with macro).
- widen=1, VSEW_32, in_data=0x12345678 → single beat, data unchanged, last=1.
- Assert sync_rst_i while in LO → next cycle out_valid_o=0, busy_o=0. The high half is never emitted, and a subsequent word is processed normally.
